// File: rtl/udp_axis_pkg.sv
// Shared types and constants for the UDP receive/transmit AXI-Stream blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package udp_axis_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_PASS = 2'd1,
      ARB_DROP = 2'd2
   } arb_state_t;

   localparam int UDP_MAX_PKT_LEN = 1500;

   // Ceiling log2 usable in parameter defaults; clog2(1) = 0
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first requester strictly after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module rr_pick
   import udp_axis_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic [SRC_W-1:0]   gnt_idx,
   output logic               any
);

   int w_idx;

   // Scan offsets from farthest to nearest so the nearest requester after ptr wins
   always_comb begin
      gnt_idx = '0;
      any     = |req;
      w_idx   = 0;
      for (int off = NUM_SRC; off >= 1; off--) begin
         w_idx = (int'(ptr) + off) % NUM_SRC;
         if (req[SRC_W'(w_idx)]) begin
            gnt_idx = SRC_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/axis_8b_rr_arbiter.sv
// Packet-locked round-robin arbiter of byte-wide sources into the 8-to-32 packer, with truncation.
// Latency: grant one cycle after request; PASS data path is zero-latency; one idle cycle between packets.
// Backpressure: m_axis_tready passes straight to the granted source; during DROP the source is always readied.
module axis_8b_rr_arbiter
   import udp_axis_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int SRC_W       = clog2(NUM_SRC),
   parameter int MAX_PKT_LEN = UDP_MAX_PKT_LEN,
   parameter int CNT_W       = clog2(MAX_PKT_LEN + 1)
) (
   input  logic                 clk_8,
   input  logic                 reset_8_n,
   input  logic [NUM_SRC*8-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]   s_axis_tvalid,
   input  logic [NUM_SRC-1:0]   s_axis_tlast,
   output logic [NUM_SRC-1:0]   s_axis_tready,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   output logic [SRC_W-1:0]     m_axis_tdest,
   input  logic                 m_axis_tready,
   output logic [SRC_W-1:0]     grant_id,
   output logic                 busy,
   output logic [15:0]          trunc_cnt
);

   arb_state_t       r_state;
   arb_state_t       w_next_state;
   logic [SRC_W-1:0] r_grant;
   logic [SRC_W-1:0] r_rr_ptr;
   logic [CNT_W-1:0] r_byte_cnt;
   logic [15:0]      r_trunc_cnt;
   logic [SRC_W-1:0] w_pick_idx;
   logic             w_pick_any;
   logic             w_src_vld;
   logic             w_src_last;
   logic [7:0]       w_src_dat;
   logic             w_at_limit;
   logic             w_pass_acc;
   logic             w_drop_acc;
   logic             w_trunc;

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
   ) u_rr_pick (
      .req     (s_axis_tvalid),
      .ptr     (r_rr_ptr),
      .gnt_idx (w_pick_idx),
      .any     (w_pick_any)
   );

   assign w_src_vld  = s_axis_tvalid[r_grant];
   assign w_src_last = s_axis_tlast[r_grant];
   assign w_src_dat  = s_axis_tdata[{r_grant, 3'b000} +: 8];

   // Last byte that may be forwarded: count of already-accepted bytes is MAX_PKT_LEN-1
   assign w_at_limit = (r_byte_cnt == CNT_W'(MAX_PKT_LEN - 1));
   assign w_pass_acc = (r_state == ARB_PASS) && w_src_vld && m_axis_tready;
   assign w_drop_acc = (r_state == ARB_DROP) && w_src_vld;
   assign w_trunc    = w_pass_acc && w_at_limit && !w_src_last;

   // State register
   always_ff @(posedge clk_8 or negedge reset_8_n) begin
      if (!reset_8_n) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: lock grant until source tlast, divert to DROP when the length cap is hit
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_any) begin
               w_next_state = ARB_PASS;
            end
         end
         ARB_PASS: begin
            if (w_pass_acc && w_src_last) begin
               w_next_state = ARB_IDLE;
            end else if (w_trunc) begin
               w_next_state = ARB_DROP;
            end
         end
         ARB_DROP: begin
            if (w_drop_acc && w_src_last) begin
               w_next_state = ARB_IDLE;
            end
         end
         default: w_next_state = ARB_IDLE;
      endcase
   end

   // Outputs: zero-latency mux of the granted source in PASS, sink-only in DROP
   always_comb begin
      s_axis_tready = '0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdest  = '0;
      case (r_state)
         ARB_PASS: begin
            m_axis_tdata           = w_src_dat;
            m_axis_tvalid          = w_src_vld;
            m_axis_tlast           = w_src_last | w_at_limit;
            m_axis_tdest           = r_grant;
            s_axis_tready[r_grant] = m_axis_tready;
         end
         ARB_DROP: begin
            s_axis_tready[r_grant] = 1'b1;
         end
         default: ;
      endcase
   end

   // Grant, round-robin pointer, per-packet byte count and saturating truncation count
   always_ff @(posedge clk_8 or negedge reset_8_n) begin
      if (!reset_8_n) begin
         r_grant     <= '0;
         r_rr_ptr    <= SRC_W'(NUM_SRC - 1);
         r_byte_cnt  <= '0;
         r_trunc_cnt <= '0;
      end else begin
         if (r_state == ARB_IDLE && w_pick_any) begin
            r_grant    <= w_pick_idx;
            r_rr_ptr   <= w_pick_idx;
            r_byte_cnt <= '0;
         end else if (w_pass_acc) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
         end
         if (w_trunc && r_trunc_cnt != 16'hFFFF) begin
            r_trunc_cnt <= r_trunc_cnt + 16'd1;
         end
      end
   end

   assign busy      = (r_state != ARB_IDLE);
   assign grant_id  = r_grant;
   assign trunc_cnt = r_trunc_cnt;

endmodule

// File: tb/tb_axis_8b_rr_arbiter.sv
// Directed bench for axis_8b_rr_arbiter with four byte sources and an 8-byte length cap.
// Sources present byte k of their packet as {src, k}; beats are logged at the sink.
// Inputs change on the falling edge or just after the rising edge; outputs are sampled between edges.
module tb_axis_8b_rr_arbiter;

   logic        clk_8 = 1'b0;
   logic        reset_8_n = 1'b0;
   logic [31:0] s_axis_tdata = '0;
   logic [3:0]  s_axis_tvalid = '0;
   logic [3:0]  s_axis_tlast = '0;
   logic [3:0]  s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic [1:0]  m_axis_tdest;
   logic        m_axis_tready = 1'b0;
   logic [1:0]  grant_id;
   logic        busy;
   logic [15:0] trunc_cnt;

   int checks = 0;
   int errors = 0;

   // Source model state
   bit   en [4]  = '{0, 0, 0, 0};
   bit   rep [4] = '{0, 0, 0, 0};
   int   len [4] = '{1, 1, 1, 1};
   int   pos [4] = '{0, 0, 0, 0};
   int   npk [4] = '{0, 0, 0, 0};
   logic [3:0] hs = '0;
   int   cyc = 0;

   // Sink log
   logic [7:0] q_dat [$];
   logic [1:0] q_dest [$];
   logic       q_last [$];
   int         q_cyc [$];

   axis_8b_rr_arbiter #(
      .NUM_SRC     (4),
      .SRC_W       (2),
      .MAX_PKT_LEN (8),
      .CNT_W       (4)
   ) dut (
      .clk_8         (clk_8),
      .reset_8_n     (reset_8_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tdest  (m_axis_tdest),
      .m_axis_tready (m_axis_tready),
      .grant_id      (grant_id),
      .busy          (busy),
      .trunc_cnt     (trunc_cnt)
   );

   always #5 clk_8 = ~clk_8;

   // Source driver and sink monitor: advance on handshakes seen before the last rising edge
   initial begin
      forever begin
         @(negedge clk_8);
         cyc++;
         for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
               pos[i]++;
               if (pos[i] >= len[i]) begin
                  npk[i]++;
                  pos[i] = 0;
                  if (!rep[i]) en[i] = 0;
               end
            end
            s_axis_tvalid[i]      = en[i];
            s_axis_tdata[i*8 +: 8] = 8'((i << 4) | pos[i]);
            s_axis_tlast[i]       = (pos[i] == len[i] - 1);
         end
         #1;
         hs = s_axis_tvalid & s_axis_tready;
         if (m_axis_tvalid && m_axis_tready) begin
            q_dat.push_back(m_axis_tdata);
            q_dest.push_back(m_axis_tdest);
            q_last.push_back(m_axis_tlast);
            q_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk_8);
      #1;
   endtask

   task automatic clear_log();
      q_dat.delete();
      q_dest.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   task automatic test_reset();
      reset_8_n = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) tick();
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest} !== 12'h000) begin
         errors++;
         $display("FAIL reset_m_axis got %0h want 0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest});
      end
      checks++;
      if (s_axis_tready !== 4'h0) begin
         errors++;
         $display("FAIL reset_s_tready got %0h want 0", s_axis_tready);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %0b want 0", busy);
      end
      checks++;
      if (grant_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_grant_id got %0d want 0", grant_id);
      end
      checks++;
      if (trunc_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_trunc_cnt got %0d want 0", trunc_cnt);
      end
      reset_8_n = 1'b1;
      repeat (2) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_req_busy got %0b want 0", busy);
      end
   endtask

   task automatic test_two_src();
      int n0, n2, k;
      logic [7:0] exp_d;
      logic [1:0] exp_s;
      n0 = npk[0];
      n2 = npk[2];
      clear_log();
      len[0] = 5; len[2] = 5; rep[0] = 0; rep[2] = 0;
      en[0] = 1; en[2] = 1;
      k = 0;
      while (k < 60 && !(npk[0] > n0 && npk[2] > n2)) begin
         tick();
         k++;
      end
      checks++;
      if (k >= 60) begin
         errors++;
         $display("FAIL two_src_timeout got npk0=%0d npk2=%0d want %0d %0d", npk[0], npk[2], n0 + 1, n2 + 1);
      end
      checks++;
      if (q_dat.size() != 10) begin
         errors++;
         $display("FAIL two_src_beats got %0d want 10", q_dat.size());
      end else begin
         for (int b = 0; b < 10; b++) begin
            exp_s = (b < 5) ? 2'd0 : 2'd2;
            exp_d = 8'((int'(exp_s) << 4) | (b % 5));
            checks++;
            if ({q_dat[b], q_dest[b], q_last[b]} !== {exp_d, exp_s, (b % 5) == 4}) begin
               errors++;
               $display("FAIL two_src_beat%0d got %0h/%0d/%0b want %0h/%0d/%0b", b,
                        q_dat[b], q_dest[b], q_last[b], exp_d, exp_s, (b % 5) == 4);
            end
         end
         checks++;
         if (q_cyc[5] - q_cyc[4] != 2) begin
            errors++;
            $display("FAIL two_src_gap got %0d cycles want 2", q_cyc[5] - q_cyc[4]);
         end
      end
   endtask

   task automatic test_rr_all();
      int k;
      logic [1:0] exp_s;
      logic [7:0] exp_d;
      clear_log();
      for (int i = 0; i < 4; i++) begin
         len[i] = 3; rep[i] = 1; pos[i] = 0; en[i] = 1;
      end
      k = 0;
      while (k < 150 && q_dat.size() < 24) begin
         tick();
         k++;
      end
      checks++;
      if (q_dat.size() < 24) begin
         errors++;
         $display("FAIL rr_all_timeout got %0d beats want 24", q_dat.size());
      end else begin
         // Pointer sits at 2 after the previous test, so the order starts at 3
         for (int b = 0; b < 24; b++) begin
            exp_s = 2'((3 + b / 3) % 4);
            exp_d = 8'((int'(exp_s) << 4) | (b % 3));
            checks++;
            if ({q_dat[b], q_dest[b], q_last[b]} !== {exp_d, exp_s, (b % 3) == 2}) begin
               errors++;
               $display("FAIL rr_all_beat%0d got %0h/%0d/%0b want %0h/%0d/%0b", b,
                        q_dat[b], q_dest[b], q_last[b], exp_d, exp_s, (b % 3) == 2);
            end
         end
      end
      for (int i = 0; i < 4; i++) rep[i] = 0;
      k = 0;
      while (k < 150 && (en[0] || en[1] || en[2] || en[3] || busy)) begin
         tick();
         k++;
      end
      checks++;
      if (k >= 150) begin
         errors++;
         $display("FAIL rr_all_drain got busy=%0b want 0", busy);
      end
   endtask

   task automatic test_trunc();
      int n1, k;
      n1 = npk[1];
      clear_log();
      len[1] = 12; pos[1] = 0; en[1] = 1;
      k = 0;
      while (k < 60 && npk[1] == n1) begin
         tick();
         k++;
      end
      checks++;
      if (k >= 60) begin
         errors++;
         $display("FAIL trunc_timeout got npk1=%0d want %0d", npk[1], n1 + 1);
      end
      checks++;
      if (q_dat.size() != 8) begin
         errors++;
         $display("FAIL trunc_beats got %0d want 8", q_dat.size());
      end else begin
         for (int b = 0; b < 8; b++) begin
            checks++;
            if ({q_dat[b], q_dest[b], q_last[b]} !== {8'(8'h10 + b), 2'd1, b == 7}) begin
               errors++;
               $display("FAIL trunc_beat%0d got %0h/%0d/%0b want %0h/1/%0b", b,
                        q_dat[b], q_dest[b], q_last[b], 8'h10 + b, b == 7);
            end
         end
      end
      checks++;
      if (trunc_cnt !== 16'd1) begin
         errors++;
         $display("FAIL trunc_cnt got %0d want 1", trunc_cnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL trunc_idle_busy got %0b want 0", busy);
      end
   endtask

   task automatic test_backpressure();
      int n0, k;
      logic [15:0] pat;
      pat = 16'b0110_1011_0101_1101;
      n0 = npk[0];
      clear_log();
      m_axis_tready = 1'b1;
      len[0] = 6; pos[0] = 0; en[0] = 1;
      for (int c = 0; c < 16; c++) begin
         tick();
         m_axis_tready = pat[c];
         #1;
         if (busy) begin
            checks++;
            if (s_axis_tready !== {3'b000, m_axis_tready}) begin
               errors++;
               $display("FAIL bp_track_c%0d got %0h want %0h", c, s_axis_tready, {3'b000, m_axis_tready});
            end
         end
      end
      m_axis_tready = 1'b1;
      k = 0;
      while (k < 40 && npk[0] == n0) begin
         tick();
         k++;
      end
      checks++;
      if (q_dat.size() != 6) begin
         errors++;
         $display("FAIL bp_beats got %0d want 6", q_dat.size());
      end else begin
         for (int b = 0; b < 6; b++) begin
            checks++;
            if ({q_dat[b], q_dest[b], q_last[b]} !== {8'(b), 2'd0, b == 5}) begin
               errors++;
               $display("FAIL bp_beat%0d got %0h/%0d/%0b want %0h/0/%0b", b,
                        q_dat[b], q_dest[b], q_last[b], b, b == 5);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int k, n0, n3;
      clear_log();
      m_axis_tready = 1'b1;
      len[2] = 6; pos[2] = 0; en[2] = 1;
      k = 0;
      while (k < 30 && q_dat.size() < 2) begin
         tick();
         k++;
      end
      #2;
      reset_8_n = 1'b0;
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest, s_axis_tready, busy, grant_id} !== 19'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs got tv=%0b tl=%0b d=%0h dest=%0d rdy=%0h busy=%0b gid=%0d want all 0",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest, s_axis_tready, busy, grant_id);
      end
      for (int i = 0; i < 4; i++) begin
         en[i] = 0; pos[i] = 0;
      end
      hs = '0;
      repeat (2) tick();
      reset_8_n = 1'b1;
      tick();
      clear_log();
      n0 = npk[0];
      n3 = npk[3];
      len[0] = 2; len[3] = 2; en[0] = 1; en[3] = 1;
      k = 0;
      while (k < 40 && !(npk[0] > n0 && npk[3] > n3)) begin
         tick();
         k++;
      end
      checks++;
      if (q_dat.size() != 4) begin
         errors++;
         $display("FAIL mid_reset_beats got %0d want 4", q_dat.size());
      end else begin
         checks++;
         if ({q_dest[0], q_dest[2]} !== {2'd0, 2'd3}) begin
            errors++;
            $display("FAIL mid_reset_order got %0d,%0d want 0,3", q_dest[0], q_dest[2]);
         end
      end
   endtask

   task automatic test_single_byte();
      int k;
      clear_log();
      m_axis_tready = 1'b1;
      len[3] = 1; pos[3] = 0; en[3] = 1;
      k = 0;
      while (k < 10 && !busy) begin
         tick();
         k++;
      end
      checks++;
      if ({busy, m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata} !== {1'b1, 1'b1, 1'b1, 2'd3, 8'h30}) begin
         errors++;
         $display("FAIL single_beat got busy=%0b tv=%0b tl=%0b dest=%0d d=%0h want 1/1/1/3/30",
                  busy, m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata);
      end
      tick();
      checks++;
      if ({busy, grant_id} !== {1'b0, 2'd3}) begin
         errors++;
         $display("FAIL single_idle got busy=%0b gid=%0d want 0/3", busy, grant_id);
      end
      tick();
      checks++;
      if (q_dat.size() != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_count got beats=%0d busy=%0b want 1/0", q_dat.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_two_src();
      test_rr_all();
      test_trunc();
      test_backpressure();
      test_reset_mid();
      test_single_byte();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_8b_rr_arbiter.md
# axis_8b_rr_arbiter

Packet-level round-robin arbiter sharing one 8-bit AXI-Stream width-converter input (the 8-to-32 packer in the UDP receive path) among NUM_SRC byte-wide sources. It sits in the clk_8 domain directly ahead of the packer. It locks the grant for a whole packet and tags each packet with its source index. It truncates packets longer than MAX_PKT_LEN so one misbehaving source cannot hold the converter indefinitely.

## Interface
- NUM_SRC, 4: number of requesting sources, 2..8.
- SRC_W, 2: width of source index, equals clog2(NUM_SRC).
- MAX_PKT_LEN, 1500: maximum bytes forwarded per packet, >= 2.
- CNT_W, 11: byte counter width, equals clog2(MAX_PKT_LEN+1).

Ports:
- clk_8  in  1  byte-side clock; the only clock.
- reset_8_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_SRC*8  source bytes; source i occupies bits [8i+7:8i].
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source end of packet.
- s_axis_tready  out  NUM_SRC  per-source ready; at most one bit high.
- m_axis_tdata  out  8  byte to converter.
- m_axis_tvalid  out  1  valid to converter.
- m_axis_tlast  out  1  end of packet, including forced truncation.
- m_axis_tdest  out  SRC_W  source index of current packet.
- m_axis_tready  in  1  converter ready (FIFO not full).
- grant_id  out  SRC_W  registered current or last grant.
- busy  out  1  high in PASS or DROP.
- trunc_cnt  out  16  saturating count of truncated packets.

## Operation
- FSM states: IDLE, PASS, DROP.
- IDLE
  - All s_axis_tready and m_axis_tvalid are low.
  - If any s_axis_tvalid is high, the arbiter selects the first valid source after rr_ptr, searching cyclically (rr_ptr+1, rr_ptr+2, …).
  - On selection: grant_id <= winner, rr_ptr <= winner, byte_cnt <= 0, and the FSM moves to PASS.
- PASS (combinational path through the granted source)
  - m_axis_tdata, m_axis_tvalid, and m_axis_tlast come from source grant_id.
  - s_axis_tready[grant_id] = m_axis_tready; all other tready bits are 0.
  - m_axis_tdest = grant_id.
  - On each accepted beat (m_axis_tvalid && m_axis_tready), byte_cnt increments.
  - Accepted beat with source tlast: go to IDLE.
  - Accepted beat where byte_cnt == MAX_PKT_LEN-1 and source tlast is low:
    - m_axis_tlast is forced high on that beat.
    - trunc_cnt increments, saturating at 0xFFFF.
    - The FSM moves to DROP.
- DROP
  - m_axis_tvalid = 0.
  - s_axis_tready[grant_id] = 1; the remaining bytes are discarded.
  - An accepted beat with tlast returns the FSM to IDLE.
- Non-granted sources are never readied. Their tvalid may stay high indefinitely without effect.
- A source dropping tvalid mid-packet stalls PASS; the grant is held.
- Arithmetic: byte_cnt is CNT_W bits and never wraps, because it is reset on every grant. trunc_cnt saturates.

## Timing
- Reset values: the FSM is in IDLE.
  - All outputs are 0, including grant_id = 0, busy = 0, and trunc_cnt = 0.
  - rr_ptr = NUM_SRC-1, so source 0 has top priority after reset.
- Asynchronous reset mid-packet takes effect immediately:
  - Outputs drop, and the partial packet is abandoned.
  - The downstream converter is reset by the same domain reset.
- Grant latency: a request seen in IDLE at cycle t gives PASS at t+1. The first beat can transfer at t+1.
- Inter-packet gap: tlast accepted at cycle t gives IDLE at t+1. The next grant is taken at t+1, and its first beat transfers at t+2. This is a one-cycle bubble per packet.
- Data path in PASS is zero latency, with no registers between source and converter.
- busy and grant_id are registered and reflect the state of the current cycle.
- A single source whose tvalid is continuously high regains the grant after each packet when no other source is requesting.

## Structure
- Shared package udp_axis_pkg:
  - FSM state enum (ARB_IDLE, ARB_PASS, ARB_DROP).
  - Default MAX_PKT_LEN constant (1500).
  - A clog2 function.
- Sub-module rr_pick:
  - Combinational round-robin priority encoder.
  - Inputs: req[NUM_SRC], ptr[SRC_W].
  - Outputs: gnt_idx[SRC_W], any.
  - Reused by later TX schedulers.
- Everything else lives in the top module.

## Test plan
- Sources 0 and 2 each offer a 5-byte packet at the same time after reset → source 0 is forwarded first with tdest=0, then source 2 with tdest=2. There is exactly one idle cycle between the two tlasts' packets.
- All 4 sources continuously offer 3-byte packets → grant order 0,1,2,3,0,… and each packet arrives intact with tlast on byte 3.
- MAX_PKT_LEN=8, source 1 sends 12 bytes → 8 bytes are output with tlast forced on byte 8. Bytes 9–12 are consumed with m_axis_tvalid=0. trunc_cnt=1, after which the FSM is in IDLE.
- m_axis_tready toggles 1-0-1 during a 6-byte packet → s_axis_tready tracks it and no bytes are duplicated or lost. byte order is preserved.
- Assert reset_8_n low mid-packet at byte 3 → all outputs are 0 in the same cycle. After release, source 0 wins the first arbitration.
- Source 3 holds a 1-byte packet (tvalid and tlast high) → it is granted, and the FSM returns to IDLE the cycle after the beat is accepted.
